// File: rtl/port_poll_sched.sv
// Round-robin poll of 8 link ports over one shared TX engine; optional single retry per port under PORT_SCHED_RETRY_EN.
// Latency 4 cycles per promptly replying port, 2 per disabled port; SEND holds tx_req until tx_ready, WAIT is bounded by TIMEOUT.
module port_poll_sched #(
  parameter int          NUM_PORT = 8,
  parameter logic [15:0] TIMEOUT  = 16'd1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_PORT-1:0] port_en,
  output logic                tx_req,
  output logic [2:0]          tx_port,
  input  logic                tx_ready,
  input  logic [NUM_PORT-1:0] rx_done,
  input  logic [NUM_PORT-1:0] rx_err,
  output logic                busy,
  output logic                sweep_done,
  output logic [NUM_PORT-1:0] stat_ok,
  output logic [NUM_PORT-1:0] stat_err,
  output logic [NUM_PORT-1:0] stat_to,
  output logic [NUM_PORT-1:0] stat_retry
);

  typedef enum logic [2:0] {IDLE, SEL, SEND, WAIT, NEXT, DONE} state_t;

  localparam logic [15:0] TIMER_LAST = TIMEOUT - 16'd1;
  localparam logic [2:0]  PTR_LAST   = 3'(NUM_PORT - 1);

  state_t              state, state_nxt;
  logic [2:0]          ptr, ptr_nxt;
  logic [NUM_PORT-1:0] mask, mask_nxt;
  logic [15:0]         timer, timer_nxt;
  logic [NUM_PORT-1:0] ok_nxt, err_nxt, to_nxt;
  logic                retry_take;

`ifdef PORT_SCHED_RETRY_EN
  logic                attempt, attempt_nxt;
  logic [NUM_PORT-1:0] retry_q, retry_nxt;
`endif

  assign tx_port = ptr;

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    mask_nxt   = mask;
    timer_nxt  = timer;
    ok_nxt     = stat_ok;
    err_nxt    = stat_err;
    to_nxt     = stat_to;
    retry_take = 1'b0;
`ifdef PORT_SCHED_RETRY_EN
    attempt_nxt = attempt;
    retry_nxt   = retry_q;
    retry_take  = !attempt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          mask_nxt  = port_en;
          ptr_nxt   = '0;
          ok_nxt    = '0;
          err_nxt   = '0;
          to_nxt    = '0;
`ifdef PORT_SCHED_RETRY_EN
          retry_nxt = '0;
`endif
          state_nxt = SEL;
        end
      end
      SEL: begin
        timer_nxt = '0;
`ifdef PORT_SCHED_RETRY_EN
        attempt_nxt = 1'b0;
`endif
        state_nxt = mask[ptr] ? SEND : NEXT;
      end
      SEND: begin
        if (tx_ready) begin
          timer_nxt = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // done beats err beats timeout; a failing first attempt may be reissued
        if (rx_done[ptr]) begin
          ok_nxt[ptr] = 1'b1;
          state_nxt   = NEXT;
        end else if ((rx_err[ptr] || (timer == TIMER_LAST)) && retry_take) begin
`ifdef PORT_SCHED_RETRY_EN
          attempt_nxt    = 1'b1;
          retry_nxt[ptr] = 1'b1;
`endif
          state_nxt = SEND;
        end else if (rx_err[ptr]) begin
          err_nxt[ptr] = 1'b1;
          state_nxt    = NEXT;
        end else if (timer == TIMER_LAST) begin
          to_nxt[ptr] = 1'b1;
          state_nxt   = NEXT;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      NEXT: begin
        if (ptr == PTR_LAST) begin
          state_nxt = DONE;
        end else begin
          ptr_nxt   = ptr + 3'd1;
          state_nxt = SEL;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      mask       <= '0;
      timer      <= '0;
      stat_ok    <= '0;
      stat_err   <= '0;
      stat_to    <= '0;
      tx_req     <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      mask       <= mask_nxt;
      timer      <= timer_nxt;
      stat_ok    <= ok_nxt;
      stat_err   <= err_nxt;
      stat_to    <= to_nxt;
      tx_req     <= (state_nxt == SEND);
      busy       <= (state_nxt != IDLE);
      sweep_done <= (state_nxt == DONE);
    end
  end

`ifdef PORT_SCHED_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attempt <= 1'b0;
      retry_q <= '0;
    end else begin
      attempt <= attempt_nxt;
      retry_q <= retry_nxt;
    end
  end

  assign stat_retry = retry_q;
`else
  assign stat_retry = '0;
`endif

endmodule

// File: tb/tb_port_poll_sched.sv
// Bench for port_poll_sched: table of sweeps with a reactive TX/RX responder, plus a mid-sweep reset sequence.
module tb_port_poll_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] port_en;
  logic       tx_req;
  logic [2:0] tx_port;
  logic       tx_ready;
  logic [7:0] rx_done;
  logic [7:0] rx_err;
  logic       busy;
  logic       sweep_done;
  logic [7:0] stat_ok;
  logic [7:0] stat_err;
  logic [7:0] stat_to;
  logic [7:0] stat_retry;

  int checks   = 0;
  int failures = 0;

  // mode per port, 2 bits: bit0 = rx_done, bit1 = rx_err in the first WAIT cycle
  typedef struct {
    logic [7:0]  en;
    logic [15:0] mode1;
    logic [15:0] mode2;
    logic [2:0]  stall_port;
    int          stall_n;
    bit          noise;
    logic [7:0]  ok;
    logic [7:0]  err;
    logic [7:0]  to;
    logic [7:0]  retry;
    int          done_cyc;
  } vec_t;

  localparam int NVEC = 6;
  vec_t       vecs[NVEC];
  logic [2:0] exp_q[$];
  vec_t       res_q[$];

  always #5 clk = ~clk;

  port_poll_sched #(.NUM_PORT(8), .TIMEOUT(16'd16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .port_en    (port_en),
    .tx_req     (tx_req),
    .tx_port    (tx_port),
    .tx_ready   (tx_ready),
    .rx_done    (rx_done),
    .rx_err     (rx_err),
    .busy       (busy),
    .sweep_done (sweep_done),
    .stat_ok    (stat_ok),
    .stat_err   (stat_err),
    .stat_to    (stat_to),
    .stat_retry (stat_retry)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         cyc;
    int         pi;
    int         att[8];
    int         stall_left;
    logic       pend;
    logic       req_open;
    logic       seen;
    logic [2:0] pport;
    logic [2:0] req_port;
    logic [2:0] e;
    logic [1:0] md;
    logic [7:0] others;
    vec_t       r;

    for (int p = 0; p < 8; p++) begin
      att[p] = 0;
      if (v.en[p]) begin
        exp_q.push_back(3'(p));
`ifdef PORT_SCHED_RETRY_EN
        if (!v.mode1[2*p]) exp_q.push_back(3'(p));
`endif
      end
    end
    res_q.push_back(v);

    port_en    = v.en;
    start      = 1'b1;
    tx_ready   = 1'b0;
    rx_done    = '0;
    rx_err     = '0;
    pend       = 1'b0;
    req_open   = 1'b0;
    seen       = 1'b0;
    pport      = '0;
    req_port   = '0;
    stall_left = v.stall_n;
    cyc        = 0;

    while (!seen && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      start    = (cyc == 3);
      port_en  = ~v.en;
      rx_done  = '0;
      rx_err   = '0;
      tx_ready = 1'b0;
      if (pend) begin
        pi = int'(pport);
        md = (att[pi] == 0) ? v.mode1[2*pi +: 2] : v.mode2[2*pi +: 2];
        rx_done[pport] = md[0];
        rx_err[pport]  = md[1];
        if (v.noise) begin
          others  = ~(8'h01 << pport);
          rx_done = rx_done | others;
          rx_err  = rx_err | others;
        end
        att[pi]++;
        pend = 1'b0;
      end
      if (req_open) chk($sformatf("v%0d_req_held", idx), {28'd0, tx_req, tx_port}, {28'd0, 1'b1, req_port});
      if (tx_req) begin
        if (stall_left > 0 && tx_port == v.stall_port) begin
          stall_left--;
          req_open = 1'b1;
          req_port = tx_port;
        end else begin
          req_open = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL v%0d_tx_port unexpected transfer actual=%0d required=none", idx, tx_port);
          end else begin
            e = exp_q.pop_front();
            if (tx_port !== e) begin
              failures++;
              $display("FAIL v%0d_tx_port actual=%0d required=%0d", idx, tx_port, e);
            end
          end
          tx_ready = 1'b1;
          pend     = 1'b1;
          pport    = tx_port;
        end
      end else begin
        req_open = 1'b0;
      end
      if (sweep_done) begin
        seen = 1'b1;
        r = res_q.pop_front();
        chk($sformatf("v%0d_done_cycle", idx), 32'(cyc), 32'(r.done_cyc));
        chk($sformatf("v%0d_stat_ok", idx), {24'd0, stat_ok}, {24'd0, r.ok});
        chk($sformatf("v%0d_stat_err", idx), {24'd0, stat_err}, {24'd0, r.err});
        chk($sformatf("v%0d_stat_to", idx), {24'd0, stat_to}, {24'd0, r.to});
        chk($sformatf("v%0d_stat_retry", idx), {24'd0, stat_retry}, {24'd0, r.retry});
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL v%0d_sweep_done not seen within %0d cycles", idx, cyc);
      res_q.delete();
    end
    chk($sformatf("v%0d_tx_left", idx), 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    start    = 1'b0;
    rx_done  = '0;
    rx_err   = '0;
    tx_ready = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_after", idx), {30'd0, busy, sweep_done}, 32'd0);
    end
    chk($sformatf("v%0d_stat_hold", idx), {24'd0, stat_ok}, {24'd0, v.ok});
  endtask

  initial begin
    int n;

    vecs[0] = '{en:8'hFF, mode1:16'h5555, mode2:16'h5555, stall_port:3'd0, stall_n:0, noise:1'b0,
                ok:8'hFF, err:8'h00, to:8'h00, retry:8'h00, done_cyc:33};
    vecs[1] = '{en:8'h81, mode1:16'h4001, mode2:16'h4001, stall_port:3'd0, stall_n:5, noise:1'b0,
                ok:8'h81, err:8'h00, to:8'h00, retry:8'h00, done_cyc:26};
    vecs[3] = '{en:8'h00, mode1:16'h0000, mode2:16'h0000, stall_port:3'd0, stall_n:0, noise:1'b0,
                ok:8'h00, err:8'h00, to:8'h00, retry:8'h00, done_cyc:17};
`ifdef PORT_SCHED_RETRY_EN
    vecs[2] = '{en:8'h06, mode1:16'h0030, mode2:16'h0030, stall_port:3'd0, stall_n:0, noise:1'b0,
                ok:8'h04, err:8'h00, to:8'h02, retry:8'h02, done_cyc:53};
    vecs[4] = '{en:8'h10, mode1:16'h0000, mode2:16'h0000, stall_port:3'd0, stall_n:0, noise:1'b1,
                ok:8'h00, err:8'h00, to:8'h10, retry:8'h10, done_cyc:51};
    vecs[5] = '{en:8'h24, mode1:16'h0420, mode2:16'h0410, stall_port:3'd0, stall_n:0, noise:1'b0,
                ok:8'h24, err:8'h00, to:8'h00, retry:8'h04, done_cyc:23};
`else
    vecs[2] = '{en:8'h06, mode1:16'h0030, mode2:16'h0030, stall_port:3'd0, stall_n:0, noise:1'b0,
                ok:8'h04, err:8'h00, to:8'h02, retry:8'h00, done_cyc:36};
    vecs[4] = '{en:8'h10, mode1:16'h0000, mode2:16'h0000, stall_port:3'd0, stall_n:0, noise:1'b1,
                ok:8'h00, err:8'h00, to:8'h10, retry:8'h00, done_cyc:34};
    vecs[5] = '{en:8'h24, mode1:16'h0420, mode2:16'h0410, stall_port:3'd0, stall_n:0, noise:1'b0,
                ok:8'h20, err:8'h04, to:8'h00, retry:8'h00, done_cyc:21};
`endif

    rst      = 1'b1;
    start    = 1'b0;
    port_en  = '0;
    tx_ready = 1'b0;
    rx_done  = '0;
    rx_err   = '0;
    #7;
    chk("reset_outputs", {tx_req, tx_port, busy, sweep_done}, 32'd0);
    chk("reset_stats", {stat_ok, stat_err, stat_to, stat_retry}, 32'd0);
    #5;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_reset", {30'd0, busy, tx_req}, 32'd0);

    // reset while waiting on port 3 after port 0 has already replied
    port_en  = 8'h09;
    rx_done  = 8'h01;
    tx_ready = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(tx_req && tx_port == 3'd3) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_reach_port3", {28'd0, tx_req, tx_port}, {28'd0, 1'b1, 3'd3});
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    chk("rst_pre_stat_ok", {24'd0, stat_ok}, 32'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_ctrl", {29'd0, busy, tx_req, sweep_done}, 32'd0);
    chk("rst_async_stats", {stat_ok, stat_err, stat_to, stat_retry}, 32'd0);
    #3;
    rst      = 1'b0;
    rx_done  = '0;
    tx_ready = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("rst_stays_idle", {29'd0, busy, tx_req, sweep_done}, 32'd0);
    end

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
